// File: rtl/spi_responder_if.sv
// SPI responder bus bundle.
// Carries the serial pins (sclk/cs_n/mosi/miso) and the parallel side
// (tx word + load strobe, rx word + valid/error pulses, busy).
//  slave  : view used by spi_responder (pins in, results out)
//  master : view used by whatever drives the link and consumes the results
interface spi_responder_if #(
  parameter int SIZE = 40
);
  logic            sclk_in;
  logic            cs_n_in;
  logic            mosi_in;
  logic            miso_out;
  logic [SIZE-1:0] tx_data_in;
  logic            tx_load_in;
  logic [SIZE-1:0] rx_data_out;
  logic            rx_valid_out;
  logic            frame_err_out;
  logic            busy_out;

  modport slave (
    input  sclk_in, cs_n_in, mosi_in, tx_data_in, tx_load_in,
    output miso_out, rx_data_out, rx_valid_out, frame_err_out, busy_out
  );

  modport master (
    output sclk_in, cs_n_in, mosi_in, tx_data_in, tx_load_in,
    input  miso_out, rx_data_out, rx_valid_out, frame_err_out, busy_out
  );
endinterface

// File: rtl/spi_responder.sv
// SPI peripheral (mode 3: SCLK idles high, MISO launched on SCLK fall,
// MOSI sampled on SCLK rise). SCLK/CS_N/MOSI are oversampled in the clk_in
// domain; frames are SIZE bits, MSB first.
// Ports:
//  clk_in  system clock, >= 8x SCLK
//  rst_in  synchronous active-high reset
//  bus     spi_responder_if.slave: sclk_in, cs_n_in, mosi_in (async pins),
//          miso_out, tx_data_in/tx_load_in (shadow load), rx_data_out,
//          rx_valid_out / frame_err_out (1-cycle pulses), busy_out
module spi_responder #(
  parameter int SIZE     = 40,
  parameter int CNT_SIZE = 6
) (
  input  logic           clk_in,
  input  logic           rst_in,
  spi_responder_if.slave bus
);

  localparam logic [1:0] RESYNC = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [CNT_SIZE-1:0] LAST_BIT = CNT_SIZE'(SIZE - 1);
  localparam logic [1:0]          SETTLED  = 2'd2;

  logic [1:0]          state;
  logic [1:0]          settle;
  logic [CNT_SIZE-1:0] bitcnt;
  logic [SIZE-1:0]     rx_shift;
  logic [SIZE-1:0]     tx_shift;
  logic [SIZE-1:0]     shadow;
  logic                overrun;
  logic                miso;
  logic [SIZE-1:0]     rx_data;
  logic                rx_valid;
  logic                frame_err;

  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  // Two-flop synchronisers plus an edge-detect stage for sclk and cs_n.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_d  <= 1'b1;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= bus.sclk_in;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= bus.cs_n_in;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= bus.mosi_in;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign cs_fall   = ~cs_s2 & cs_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= RESYNC;
      settle    <= '0;
      bitcnt    <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      shadow    <= '0;
      overrun   <= 1'b0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (bus.tx_load_in) begin
        shadow <= bus.tx_data_in;
      end

      case (state)
        // The sync flops reset to "deselected", so cs_s2 only reflects the
        // pin once the pipeline has refilled; waiting for that keeps a
        // mid-frame reset from re-entering the aborted frame.
        RESYNC: begin
          miso <= 1'b0;
          if (settle != SETTLED) begin
            settle <= settle + 2'd1;
          end else if (cs_s2) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state    <= SHIFT;
            tx_shift <= shadow;
            bitcnt   <= '0;
          end
        end

        // cs_n rise wins over a coincident SCLK edge.
        SHIFT: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            miso      <= 1'b0;
            state     <= IDLE;
          end else if (sclk_fall) begin
            miso     <= tx_shift[SIZE-1];
            tx_shift <= {tx_shift[SIZE-2:0], 1'b0};
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[SIZE-2:0], mosi_s2};
            bitcnt   <= bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (cs_rise) begin
            if (overrun) begin
              frame_err <= 1'b1;
            end else begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
            overrun <= 1'b0;
            miso    <= 1'b0;
            state   <= IDLE;
          end else if (sclk_rise) begin
            overrun <= 1'b1;
          end
        end

        default: state <= RESYNC;
      endcase
    end
  end

  assign bus.miso_out      = miso;
  assign bus.rx_data_out   = rx_data;
  assign bus.rx_valid_out  = rx_valid;
  assign bus.frame_err_out = frame_err;
  assign bus.busy_out      = (state == SHIFT) || (state == HOLD);

endmodule

// File: tb/tb_spi_responder.sv
// Directed testbench for spi_responder (SIZE=40, SCLK half-period 8 clk).
// A behavioural mode-3 master drives the pins; pulse monitors count
// rx_valid/frame_err events, and each step checks against hand-computed values.
module tb_spi_responder;

  localparam int SIZE = 40;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;

  spi_responder_if #(.SIZE(SIZE)) bus ();

  spi_responder #(.SIZE(SIZE), .CNT_SIZE(6)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rx_valid_out) n_valid <= n_valid + 1;
    if (bus.frame_err_out) n_err <= n_err + 1;
    if (bus.rx_valid_out && bus.frame_err_out) n_both <= n_both + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_tx(input logic [SIZE-1:0] val);
    @(negedge clk);
    bus.tx_data_in = val;
    bus.tx_load_in = 1'b1;
    wait_clks(1);
    bus.tx_load_in = 1'b0;
  endtask

  // One mode-3 frame with nrise SCLK cycles. rst_at>0 pulses reset after that
  // rising edge; load_at>0 loads load_val into the shadow after that edge.
  task automatic spi_frame(input logic [SIZE-1:0] data, input int nrise,
                           input int rst_at, input int load_at,
                           input logic [SIZE-1:0] load_val,
                           output logic [SIZE-1:0] got, output logic busy_seen);
    got = '0;
    busy_seen = 1'b0;
    @(negedge clk);
    bus.cs_n_in = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nrise; i++) begin
      bus.sclk_in = 1'b0;
      bus.mosi_in = (i < SIZE) ? data[SIZE-1-i] : 1'b0;
      wait_clks(HALF);
      bus.sclk_in = 1'b1;
      if (i < SIZE) got = {got[SIZE-2:0], bus.miso_out};
      wait_clks(HALF);
      if (i == 0) busy_seen = bus.busy_out;
      if (i + 1 == rst_at) begin
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
      end
      if (i + 1 == load_at) load_tx(load_val);
    end
    wait_clks(HALF);
    bus.cs_n_in = 1'b1;
    bus.mosi_in = 1'b0;
    wait_clks(12);
  endtask

  logic [SIZE-1:0] got;
  logic            busy_seen;
  int              v0, e0;

  initial begin
    bus.sclk_in    = 1'b1;
    bus.cs_n_in    = 1'b1;
    bus.mosi_in    = 1'b0;
    bus.tx_data_in = '0;
    bus.tx_load_in = 1'b0;

    // 1: reset state
    wait_clks(3);
    check("rst_miso", 64'(bus.miso_out), 64'h0);
    check("rst_rx_data", 64'(bus.rx_data_out), 64'h0);
    check("rst_rx_valid", 64'(bus.rx_valid_out), 64'h0);
    check("rst_frame_err", 64'(bus.frame_err_out), 64'h0);
    check("rst_busy", 64'(bus.busy_out), 64'h0);
    rst = 1'b0;
    wait_clks(6);
    check("idle_busy", 64'(bus.busy_out), 64'h0);

    // 2: good frame, both directions
    load_tx(40'hA5_0000_00FF);
    v0 = n_valid; e0 = n_err;
    spi_frame(40'h12_3456_789A, 40, 0, 0, '0, got, busy_seen);
    check("good_busy", 64'(busy_seen), 64'h1);
    check("good_miso_word", 64'(got), 64'hA5_0000_00FF);
    check("good_rx_data", 64'(bus.rx_data_out), 64'h12_3456_789A);
    check("good_valid_cnt", 64'(n_valid - v0), 64'h1);
    check("good_err_cnt", 64'(n_err - e0), 64'h0);
    check("good_miso_idle", 64'(bus.miso_out), 64'h0);
    check("good_busy_after", 64'(bus.busy_out), 64'h0);

    // 3: short frame (20 bits)
    v0 = n_valid; e0 = n_err;
    spi_frame(40'hFF_FFFF_FFFF, 20, 0, 0, '0, got, busy_seen);
    check("short_err_cnt", 64'(n_err - e0), 64'h1);
    check("short_valid_cnt", 64'(n_valid - v0), 64'h0);
    check("short_rx_hold", 64'(bus.rx_data_out), 64'h12_3456_789A);

    // 4: overrun (45 bits)
    v0 = n_valid; e0 = n_err;
    spi_frame(40'h00_0000_0001, 45, 0, 0, '0, got, busy_seen);
    check("long_err_cnt", 64'(n_err - e0), 64'h1);
    check("long_valid_cnt", 64'(n_valid - v0), 64'h0);
    check("long_rx_hold", 64'(bus.rx_data_out), 64'h12_3456_789A);

    // 5: reset after bit 10, then a full all-ones frame
    v0 = n_valid; e0 = n_err;
    spi_frame(40'h55_5555_5555, 40, 10, 0, '0, got, busy_seen);
    check("midrst_valid_cnt", 64'(n_valid - v0), 64'h0);
    check("midrst_err_cnt", 64'(n_err - e0), 64'h0);
    check("midrst_rx_cleared", 64'(bus.rx_data_out), 64'h0);
    check("midrst_busy", 64'(bus.busy_out), 64'h0);
    v0 = n_valid; e0 = n_err;
    spi_frame(40'hFF_FFFF_FFFF, 40, 0, 0, '0, got, busy_seen);
    check("after_rst_rx_data", 64'(bus.rx_data_out), 64'hFF_FFFF_FFFF);
    check("after_rst_valid_cnt", 64'(n_valid - v0), 64'h1);
    check("after_rst_miso_word", 64'(got), 64'h0);

    // 6: mid-frame shadow load affects only the next frame
    load_tx(40'h2);
    spi_frame(40'h00_0F0F_0F0F, 40, 0, 5, 40'h1, got, busy_seen);
    check("shadow_n_miso", 64'(got), 64'h2);
    check("shadow_n_rx", 64'(bus.rx_data_out), 64'h00_0F0F_0F0F);
    spi_frame(40'h80_0000_0001, 40, 0, 0, '0, got, busy_seen);
    check("shadow_n1_miso", 64'(got), 64'h1);
    check("shadow_n1_rx", 64'(bus.rx_data_out), 64'h80_0000_0001);

    check("valid_err_exclusive", 64'(n_both), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
